// File: rtl/n_adder_arbiter_seq.sv
// n_adder_arbiter_seq: one shared N-bit ripple adder time-multiplexed to add two
// WORDS*N-bit operands over WORDS cycles, least significant word first, with a
// round-robin arbiter in front and a registered valid/ready result port behind.

// Single-word adder that is reused for every word of the wide operation.
module n_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    // Widen by one bit so the carry falls out of the same addition.
    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

module n_adder_arbiter_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [N*WORDS-1:0]   req0_a,
    input  logic [N*WORDS-1:0]   req0_b,
    input  logic                 req0_cin,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [N*WORDS-1:0]   req1_a,
    input  logic [N*WORDS-1:0]   req1_b,
    input  logic                 req1_cin,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 out_id
);

    localparam int W    = N * WORDS;
    // Keep the word index at least one bit wide so WORDS=1 still elaborates.
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            ptr;        // requester that wins when both are valid
    logic [IDXW-1:0] idx;        // word currently being added
    logic            carry;      // carry chained from word k-1 into word k
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;

    logic            grant_id;
    logic            accept;
    logic            last_word;
    logic [N-1:0]    a_word;
    logic [N-1:0]    b_word;
    logic [N-1:0]    s_word;
    logic            c_word;

    // Pick the requester to serve: a lone valid wins, a tie goes to the pointer.
    always_comb begin
        // NOTE: default first so every path assigns grant_id and no latch is inferred.
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ptr;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is only offered while idle and out of reset, to the granted side only.
    assign req0_ready = rstn && (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = rstn && (state == IDLE) && req1_valid &&  grant_id;
    assign accept     = req0_ready || req1_ready;

    assign last_word  = (idx == IDX_LAST);

    // Route the current word of each captured operand to the shared adder.
    always_comb begin
        a_word = a_reg[int'(idx)*N +: N];
        b_word = b_reg[int'(idx)*N +: N];
    end

    n_adder #(.N(N)) u_adder (
        .a     (a_word),
        .b     (b_word),
        .c_in  (carry),
        .s     (s_word),
        .c_out (c_word)
    );

    // Control FSM with registered operands, carry chain and result outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_id    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= grant_id ? req1_a   : req0_a;
                        b_reg  <= grant_id ? req1_b   : req0_b;
                        carry  <= grant_id ? req1_cin : req0_cin;
                        out_id <= grant_id;
                        ptr    <= ~grant_id;
                        idx    <= '0;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    out_sum[int'(idx)*N +: N] <= s_word;
                    carry                     <= c_word;
                    idx                       <= idx + 1'b1;
                    if (last_word) begin
                        out_cout  <= c_word;
                        // Same-sign operands whose sum flips sign overflowed;
                        // s_word[N-1] is the MSB of the full-width sum here.
                        out_ovf   <= (a_reg[W-1] == b_reg[W-1]) &&
                                     (s_word[N-1] != a_reg[W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_adder_arbiter_seq.sv
// Testbench for n_adder_arbiter_seq: directed vectors with hand-computed results
// pushed to a scoreboard; a monitor checks each result, latency and accepts.
module tb_n_adder_arbiter_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk  = 1'b0;
    logic         rstn = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req0_ready;
    logic         req1_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req0_cin = 1'b0;
    logic         req1_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_id;

    always #5 clk = ~clk;

    n_adder_arbiter_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_id     (out_id)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   acc_log[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   last_acc = -100;
    int   last_hs  = -100;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] sum, input logic cout, input logic ovf, input logic id);
        exp_t x;
        x.sum  = sum;
        x.cout = cout;
        x.ovf  = ovf;
        x.id   = id;
        sb.push_back(x);
    endtask

    // Present an operation on one requester, hold it until accepted, then drop valid.
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n = 0;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end
        forever begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: requester %0d got no ready, want ready within 200 cycles", id);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    // Wait until every expected result has been consumed, then realign after an edge.
    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n >= 100, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: log accepts, check latency on out_valid rise, score each result handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_valid = 1'b0;
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                check("ready_onehot", req0_ready & req1_ready, 0);
                last_acc = cyc + 1;
                acc_log.push_back(cyc + 1);
            end
            if (out_valid && !prev_valid) begin
                check("latency", cyc - last_acc, WORDS);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got result sum %0h, want no result", out_sum);
                end else begin
                    e = sb.pop_front();
                    check("sum",  out_sum,  e.sum);
                    check("cout", out_cout, e.cout);
                    check("ovf",  out_ovf,  e.ovf);
                    check("id",   out_id,   e.id);
                end
                last_hs = cyc + 1;
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;

        // Reset state, with a request pending to show ready is suppressed.
        #1 rstn = 1'b0;
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_cout",  out_cout,  0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_out_id",    out_id,    0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Basic add; meanwhile req1 is valid during RUN and must not be readied.
        push_exp(32'h0000000F, 1'b0, 1'b0, 1'b0);
        send(0, 32'h00000005, 32'h0000000A, 1'b0);
        req1_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("run_req0_ready", req0_ready, 0);
            check("run_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_drain();

        // Carry chaining through the word boundary and out of the MSB word.
        push_exp(32'h00000100, 1'b0, 1'b0, 1'b1);
        send(1, 32'h000000FF, 32'h00000001, 1'b0);
        wait_drain();
        push_exp(32'h00000000, 1'b1, 1'b0, 1'b1);
        send(1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_drain();

        // Signed overflow, and a mixed-sign add with carry but no overflow.
        push_exp(32'h80000000, 1'b0, 1'b1, 1'b0);
        send(0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_drain();
        push_exp(32'h00000014, 1'b1, 1'b0, 1'b1);
        send(1, 32'h0000001E, 32'hFFFFFFF6, 1'b0);
        wait_drain();

        // Arbitration: both requesters continuously valid, grants alternate 0,1,0,1.
        push_exp(32'h11223344, 1'b0, 1'b0, 1'b0);
        push_exp(32'h00000000, 1'b1, 1'b1, 1'b1);
        push_exp(32'h00000000, 1'b1, 1'b0, 1'b0);
        push_exp(32'h000001FF, 1'b0, 1'b0, 1'b1);
        n0 = acc_log.size();
        fork
            begin
                send(0, 32'h01020304, 32'h10203040, 1'b0);
                send(0, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
            end
            begin
                send(1, 32'h80000000, 32'h80000000, 1'b0);
                send(1, 32'h00000100, 32'h000000FF, 1'b0);
            end
        join
        wait_drain();
        check("arb_accepts", acc_log.size() - n0, 4);
        if (acc_log.size() - n0 == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("accept_spacing", acc_log[n0 + i] - acc_log[n0 + i - 1], WORDS + 2);
            end
        end

        // Backpressure: hold out_ready low, result and readies must stay put.
        out_ready = 1'b0;
        push_exp(32'h23456789, 1'b0, 1'b0, 1'b0);
        send(0, 32'h12345678, 32'h11111111, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_timeout", n >= 50, 0);
        @(posedge clk); #1;
        push_exp(32'h00000003, 1'b0, 1'b0, 1'b1);
        fork
            send(1, 32'h00000001, 32'h00000002, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_out_valid",  out_valid,  1);
                    check("bp_out_sum",    out_sum,    32'h23456789);
                    check("bp_out_id",     out_id,     0);
                    check("bp_req0_ready", req0_ready, 0);
                    check("bp_req1_ready", req1_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        check("bp_next_grant", last_acc - last_hs, 1);
        wait_drain();

        // Reset in RUN word 2: outputs clear at once and the result never appears.
        send(0, 32'h11111111, 32'h22222222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_sum",   out_sum,   0);
        check("abort_out_cout",  out_cout,  0);
        check("abort_out_ovf",   out_ovf,   0);
        check("abort_out_id",    out_id,    0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (WORDS + 2) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        @(posedge clk); #1;

        // Pointer back at requester 0: a tie goes to req0 first.
        push_exp(32'h01000100, 1'b0, 1'b0, 1'b0);
        push_exp(32'h00000000, 1'b1, 1'b0, 1'b1);
        fork
            send(0, 32'h00FF00FF, 32'h00010001, 1'b0);
            send(1, 32'hAAAAAAAA, 32'h55555555, 1'b1);
        join
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
